// File: rtl/ryu_pkg.sv
// ryu_pkg: shared state, sprite and direction encodings for the Ryu motion controller
package ryu_pkg;
    localparam int SPRITE_W = 107;
    localparam int SPRITE_H = 144;
    typedef enum logic [1:0] {SPR_STAND, SPR_WALK, SPR_CROUCH, SPR_JUMP} sprite_sel_t;
    typedef enum logic [2:0] {ST_IDLE, ST_WALK, ST_CROUCH, ST_JUMP, ST_LAND} motion_state_t;
    typedef enum logic [1:0] {DIR_NONE, DIR_RIGHT, DIR_LEFT} dir_t;
    function automatic sprite_sel_t sprite_of(motion_state_t s);
        return s == ST_WALK ? SPR_WALK :
               s == ST_JUMP ? SPR_JUMP :
               (s == ST_CROUCH || s == ST_LAND) ? SPR_CROUCH : SPR_STAND;
    endfunction
endpackage

// File: rtl/ryu_jump_integrator.sv
// ryu_jump_integrator: vertical position/velocity integrator with ceiling and ground clamps
module ryu_jump_integrator #(
    parameter int GROUND_Y = 300,
    parameter int Y_MIN    = 0,
    parameter int JUMP_V   = 12,
    parameter int GRAVITY  = 1
) (
    input  logic       vga_clk,
    input  logic       reset,
    input  logic       launch,
    input  logic       step,
    output logic [9:0] y,
    output logic       landed
);
    localparam logic signed [10:0] GY_S   = 11'(GROUND_Y);
    localparam logic signed [10:0] YMIN_S = 11'(Y_MIN);
    localparam logic signed [5:0]  JV     = 6'(JUMP_V);
    localparam logic signed [5:0]  GR     = 6'(GRAVITY);
    logic [9:0]         y_q, y_d;
    logic signed [5:0]  vy_q, vy_d;
    logic signed [10:0] y_cur, vy_ext, y_next;
    assign y_cur  = {1'b0, y_q};
    assign vy_ext = {{5{vy_q[5]}}, vy_q};
    assign y_next = y_cur + vy_ext;
    assign landed = step & ~vy_q[5] & (|vy_q) & (y_next >= GY_S);
    assign y      = y_q;
    always_comb begin
        y_d  = y_q;
        vy_d = vy_q;
        if (launch) begin
            vy_d = -JV;
        end else if (step) begin
            y_d  = landed ? GY_S[9:0] : (y_next < YMIN_S) ? YMIN_S[9:0] : y_next[9:0];
            vy_d = landed ? 6'sd0 : vy_q + GR;
        end
    end
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            y_q  <= 10'(GROUND_Y);
            vy_q <= '0;
        end else begin
            y_q  <= y_d;
            vy_q <= vy_d;
        end
    end
endmodule

// File: rtl/ryu_motion_ctrl.sv
// ryu_motion_ctrl: per-frame Ryu state machine, X motion and sprite selection
module ryu_motion_ctrl
    import ryu_pkg::*;
#(
    parameter int START_X     = 100,
    parameter int GROUND_Y    = 300,
    parameter int Y_MIN       = 0,
    parameter int X_MIN       = 0,
    parameter int X_MAX       = 640 - SPRITE_W,
    parameter int WALK_SPEED  = 2,
    parameter int JUMP_V      = 12,
    parameter int GRAVITY     = 1,
    parameter int LAND_FRAMES = 4
) (
    input  logic       vga_clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       key_jump,
    input  logic       key_crouch,
    output logic [9:0] ryu_x,
    output logic [9:0] ryu_y,
    output logic [1:0] sprite_sel,
    output logic       facing_left,
    output logic       airborne
);
    localparam logic [10:0] WS    = 11'(WALK_SPEED);
    localparam logic [10:0] XMIN  = 11'(X_MIN);
    localparam logic [10:0] XMAX  = 11'(X_MAX);
    localparam logic [3:0]  LAND0 = 4'(LAND_FRAMES - 1);
    motion_state_t state_q, state_d;
    dir_t          hdir_q, hdir_d, dir, mv_dir;
    logic [9:0]    x_q, x_d;
    logic [10:0]   x_cur, x_right, x_left;
    logic [3:0]    land_q, land_d;
    logic          facing_q, facing_d, jump_prev_q, jump_prev_d;
    logic          jump_edge, launch, step, landed;
    assign dir       = (key_right & ~key_left) ? DIR_RIGHT : (key_left & ~key_right) ? DIR_LEFT : DIR_NONE;
    assign jump_edge = key_jump & ~jump_prev_q;
    always_comb begin
        state_d     = state_q;
        hdir_d      = hdir_q;
        facing_d    = facing_q;
        land_d      = land_q;
        jump_prev_d = jump_prev_q;
        launch      = 1'b0;
        step        = 1'b0;
        mv_dir      = DIR_NONE;
        if (frame_tick) begin
            jump_prev_d = key_jump;
            case (state_q)
                ST_JUMP: begin
                    step   = 1'b1;
                    mv_dir = hdir_q;
                    if (landed) begin
                        state_d = ST_LAND;
                        land_d  = LAND0;
                    end
                end
                ST_LAND: begin
                    state_d = (land_q == 4'd0) ? ST_IDLE : ST_LAND;
                    land_d  = (land_q == 4'd0) ? land_q : land_q - 4'd1;
                end
                default: begin
                    facing_d = (dir == DIR_NONE) ? facing_q : (dir == DIR_LEFT);
                    if (jump_edge) begin
                        state_d = ST_JUMP;
                        hdir_d  = dir;
                        launch  = 1'b1;
                    end else if (key_crouch) begin
                        state_d = ST_CROUCH;
                    end else if (dir != DIR_NONE) begin
                        state_d = ST_WALK;
                        mv_dir  = dir;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            endcase
        end
    end
    // X arithmetic is widened by one bit so the right-hand clamp sees overflow past X_MAX
    assign x_cur   = {1'b0, x_q};
    assign x_right = x_cur + WS;
    assign x_left  = x_cur - WS;
    always_comb begin
        x_d = mv_dir == DIR_RIGHT ? ((x_right > XMAX) ? XMAX[9:0] : x_right[9:0]) :
              mv_dir == DIR_LEFT  ? ((x_cur < XMIN + WS) ? XMIN[9:0] : x_left[9:0]) : x_q;
    end
    always_ff @(posedge vga_clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            hdir_q      <= DIR_NONE;
            x_q         <= 10'(START_X);
            facing_q    <= 1'b0;
            land_q      <= '0;
            jump_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hdir_q      <= hdir_d;
            x_q         <= x_d;
            facing_q    <= facing_d;
            land_q      <= land_d;
            jump_prev_q <= jump_prev_d;
        end
    end
    ryu_jump_integrator #(
        .GROUND_Y (GROUND_Y),
        .Y_MIN    (Y_MIN),
        .JUMP_V   (JUMP_V),
        .GRAVITY  (GRAVITY)
    ) u_jump (
        .vga_clk (vga_clk),
        .reset   (reset),
        .launch  (launch),
        .step    (step),
        .y       (ryu_y),
        .landed  (landed)
    );
    assign ryu_x       = x_q;
    assign sprite_sel  = sprite_of(state_q);
    assign facing_left = facing_q;
    assign airborne    = (state_q == ST_JUMP);
endmodule

// File: tb/tb_ryu_motion_ctrl.sv
// tb_ryu_motion_ctrl: directed scenario tests for ryu_motion_ctrl
module tb_ryu_motion_ctrl;
    logic       vga_clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       key_left = 1'b0, key_right = 1'b0, key_jump = 1'b0, key_crouch = 1'b0;
    logic [9:0] ryu_x, ryu_y;
    logic [1:0] sprite_sel;
    logic       facing_left, airborne;
    int         checks = 0;
    int         errors = 0;

    ryu_motion_ctrl dut (
        .vga_clk     (vga_clk),
        .reset       (reset),
        .frame_tick  (frame_tick),
        .key_left    (key_left),
        .key_right   (key_right),
        .key_jump    (key_jump),
        .key_crouch  (key_crouch),
        .ryu_x       (ryu_x),
        .ryu_y       (ryu_y),
        .sprite_sel  (sprite_sel),
        .facing_left (facing_left),
        .airborne    (airborne)
    );

    always #5 vga_clk = ~vga_clk;

    task automatic tick();
        @(negedge vga_clk) frame_tick = 1'b1;
        @(negedge vga_clk) frame_tick = 1'b0;
    endtask

    task automatic set_keys(input logic l, input logic r, input logic j, input logic c);
        key_left = l; key_right = r; key_jump = j; key_crouch = c;
    endtask

    task automatic do_reset();
        set_keys(0, 0, 0, 0);
        @(negedge vga_clk) reset = 1'b1;
        @(negedge vga_clk);
        @(negedge vga_clk) reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (ryu_x !== 10'd100) begin errors++; $display("FAIL reset_x got %0d want 100", ryu_x); end
        checks++; if (ryu_y !== 10'd300) begin errors++; $display("FAIL reset_y got %0d want 300", ryu_y); end
        checks++; if (sprite_sel !== 2'd0 || airborne !== 1'b0 || facing_left !== 1'b0) begin
            errors++; $display("FAIL reset_flags got sel=%0d air=%0b face=%0b want 0/0/0", sprite_sel, airborne, facing_left);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (ryu_x !== 10'd100 || ryu_y !== 10'd300 || sprite_sel !== 2'd0 || airborne !== 1'b0) begin
                errors++; $display("FAIL idle_tick%0d got x=%0d y=%0d sel=%0d air=%0b want 100/300/0/0", i, ryu_x, ryu_y, sprite_sel, airborne);
            end
        end
    endtask

    task automatic test_walk();
        do_reset();
        set_keys(0, 1, 0, 0);
        for (int i = 0; i < 10; i++) tick();
        checks++; if (ryu_x !== 10'd120) begin errors++; $display("FAIL walk_right_x got %0d want 120", ryu_x); end
        checks++; if (sprite_sel !== 2'd1 || facing_left !== 1'b0) begin
            errors++; $display("FAIL walk_right_sel got sel=%0d face=%0b want 1/0", sprite_sel, facing_left);
        end
        repeat (5) @(negedge vga_clk);
        checks++; if (ryu_x !== 10'd120) begin errors++; $display("FAIL hold_no_tick_x got %0d want 120", ryu_x); end
        set_keys(1, 1, 0, 0);
        for (int i = 0; i < 3; i++) tick();
        checks++; if (ryu_x !== 10'd120 || sprite_sel !== 2'd0) begin
            errors++; $display("FAIL both_keys got x=%0d sel=%0d want 120/0", ryu_x, sprite_sel);
        end
        set_keys(1, 0, 0, 0);
        tick();
        checks++; if (ryu_x !== 10'd118 || sprite_sel !== 2'd1 || facing_left !== 1'b1) begin
            errors++; $display("FAIL walk_left got x=%0d sel=%0d face=%0b want 118/1/1", ryu_x, sprite_sel, facing_left);
        end
        set_keys(0, 0, 0, 0);
        tick();
        checks++; if (sprite_sel !== 2'd0 || facing_left !== 1'b1) begin
            errors++; $display("FAIL idle_keeps_facing got sel=%0d face=%0b want 0/1", sprite_sel, facing_left);
        end
        set_keys(0, 1, 0, 1);
        tick();
        checks++; if (sprite_sel !== 2'd2 || ryu_x !== 10'd118 || facing_left !== 1'b0) begin
            errors++; $display("FAIL crouch got sel=%0d x=%0d face=%0b want 2/118/0", sprite_sel, ryu_x, facing_left);
        end
        set_keys(0, 0, 1, 1);
        tick();
        checks++; if (sprite_sel !== 2'd3 || airborne !== 1'b1) begin
            errors++; $display("FAIL crouch_jump got sel=%0d air=%0b want 3/1", sprite_sel, airborne);
        end
    endtask

    task automatic test_jump();
        do_reset();
        set_keys(0, 0, 1, 0);
        tick();
        checks++; if (sprite_sel !== 2'd3 || airborne !== 1'b1 || ryu_y !== 10'd300) begin
            errors++; $display("FAIL jump_launch got sel=%0d air=%0b y=%0d want 3/1/300", sprite_sel, airborne, ryu_y);
        end
        set_keys(0, 0, 0, 0);
        for (int t = 1; t <= 29; t++) begin
            tick();
            if (t == 1 || t == 12 || t == 13 || t == 24) begin
                logic [9:0] ey;
                ey = (t == 1 || t == 24) ? 10'd288 : 10'd222;
                checks++; if (ryu_y !== ey) begin errors++; $display("FAIL jump_y_t%0d got %0d want %0d", t, ryu_y, ey); end
            end
            if (t == 25) begin
                checks++; if (ryu_y !== 10'd300 || sprite_sel !== 2'd2 || airborne !== 1'b0) begin
                    errors++; $display("FAIL jump_land got y=%0d sel=%0d air=%0b want 300/2/0", ryu_y, sprite_sel, airborne);
                end
            end
            if (t == 28) begin
                checks++; if (sprite_sel !== 2'd2) begin errors++; $display("FAIL land_t28 got sel=%0d want 2", sprite_sel); end
            end
        end
        checks++; if (sprite_sel !== 2'd0 || ryu_y !== 10'd300 || ryu_x !== 10'd100) begin
            errors++; $display("FAIL jump_idle_t29 got sel=%0d y=%0d x=%0d want 0/300/100", sprite_sel, ryu_y, ryu_x);
        end
    endtask

    task automatic test_held_jump();
        int air_ticks, launches;
        logic prev_air;
        do_reset();
        air_ticks = 0; launches = 0; prev_air = 1'b0;
        set_keys(0, 0, 1, 0);
        for (int i = 0; i < 60; i++) begin
            tick();
            if (airborne) air_ticks++;
            if (airborne && !prev_air) launches++;
            prev_air = airborne;
        end
        checks++; if (launches != 1) begin errors++; $display("FAIL held_jump_launches got %0d want 1", launches); end
        checks++; if (air_ticks != 25) begin errors++; $display("FAIL held_jump_air_ticks got %0d want 25", air_ticks); end
        checks++; if (sprite_sel !== 2'd0 || ryu_y !== 10'd300) begin
            errors++; $display("FAIL held_jump_end got sel=%0d y=%0d want 0/300", sprite_sel, ryu_y);
        end
    endtask

    task automatic test_clamp();
        int n;
        do_reset();
        set_keys(0, 1, 0, 0);
        for (int i = 0; i < 215; i++) tick();
        checks++; if (ryu_x !== 10'd530) begin errors++; $display("FAIL clamp_walk_x got %0d want 530", ryu_x); end
        set_keys(0, 1, 1, 0);
        tick();
        checks++; if (ryu_x !== 10'd530 || airborne !== 1'b1) begin
            errors++; $display("FAIL clamp_launch got x=%0d air=%0b want 530/1", ryu_x, airborne);
        end
        tick();
        checks++; if (ryu_x !== 10'd532) begin errors++; $display("FAIL clamp_air1 got %0d want 532", ryu_x); end
        tick();
        checks++; if (ryu_x !== 10'd533) begin errors++; $display("FAIL clamp_air2 got %0d want 533", ryu_x); end
        tick();
        checks++; if (ryu_x !== 10'd533) begin errors++; $display("FAIL clamp_air3 got %0d want 533", ryu_x); end
        set_keys(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick();
        checks++; if (ryu_x !== 10'd533 || facing_left !== 1'b0) begin
            errors++; $display("FAIL air_left_ignored got x=%0d face=%0b want 533/0", ryu_x, facing_left);
        end
        n = 0;
        while (airborne && n < 40) begin tick(); n++; end
        checks++; if (airborne !== 1'b0 || ryu_y !== 10'd300 || sprite_sel !== 2'd2 || ryu_x !== 10'd533) begin
            errors++; $display("FAIL clamp_land got air=%0b y=%0d sel=%0d x=%0d want 0/300/2/533", airborne, ryu_y, sprite_sel, ryu_x);
        end
    endtask

    task automatic test_reset_midjump();
        do_reset();
        set_keys(0, 1, 1, 0);
        tick();
        for (int t = 1; t <= 9; t++) tick();
        checks++; if (ryu_y !== 10'd228 || ryu_x !== 10'd118) begin
            errors++; $display("FAIL midjump_t9 got y=%0d x=%0d want 228/118", ryu_y, ryu_x);
        end
        @(negedge vga_clk) begin frame_tick = 1'b1; reset = 1'b1; end
        @(negedge vga_clk) begin frame_tick = 1'b0; reset = 1'b0; end
        checks++; if (ryu_y !== 10'd300 || ryu_x !== 10'd100 || sprite_sel !== 2'd0 || airborne !== 1'b0) begin
            errors++; $display("FAIL reset_midjump got y=%0d x=%0d sel=%0d air=%0b want 300/100/0/0", ryu_y, ryu_x, sprite_sel, airborne);
        end
    endtask

    initial begin
        test_reset();
        test_walk();
        test_jump();
        test_held_jump();
        test_clamp();
        test_reset_midjump();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
